// File: rtl/display_arbiter_pkg.sv
// rtl/display_arbiter_pkg.sv - shared types and constants for the display arbiter
// Purpose : arbiter state encoding, requester limit, 100 MHz timing defaults and
//           a small index helper used by the arbiter and its priority picker.
// Ports   : none (package).
package display_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ANNOUNCE,
        OWNED
    } arb_state_t;

    localparam int DISPLAY_ARB_MAX_REQ  = 8;
    localparam int DEFAULT_HOLD_CYCLES  = 50_000_000;
    localparam int DEFAULT_FLASH_CYCLES = 25_000_000;

    // Next requester index with wrap from n-1 back to 0.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner search
// Purpose : finds the first asserted request at or after a start index, wrapping.
// Ports   : req    - request vector, one bit per requester
//           start  - index where the search begins (must be < NUM_REQ)
//           winner - index of the first requester found (0 when none)
//           found  - 1 when any request bit is set
module rr_priority_picker
    import display_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         start,
    output logic [2:0]         winner,
    output logic               found
);

    logic [DISPLAY_ARB_MAX_REQ-1:0] req_ext;
    logic [3:0]                     slot;

    // Scan offsets from the farthest to the nearest so the nearest hit is the
    // last assignment and therefore wins, without needing an early exit.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        winner               = '0;
        found                = 1'b0;
        slot                 = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, start} + 4'(i);
            if (slot >= 4'(NUM_REQ)) begin
                slot = slot - 4'(NUM_REQ);
            end
            if (req_ext[slot[2:0]]) begin
                winner = slot[2:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner arbitration for the dword display
// Purpose : time-shares the 8-digit display between NUM_REQ requesters with a
//           minimum hold per owner and a flash announcing each new owner.
// Ports   : clock_100mhz     - system clock
//           reset            - synchronous, active-high
//           req              - level request per requester
//           word_in          - NUM_REQ packed 32-bit words, requester i at [i*32 +: 32]
//           lock             - freezes the current owner
//           grant            - one-hot owner, 0 when idle
//           dword            - word to display
//           flash_upper_half - flash request, upper display half
//           flash_lower_half - flash request, lower display half
//           owner_idx        - owner index, 0 when idle
//           owner_valid      - 1 while someone owns the display
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
    parameter int FLASH_CYCLES = DEFAULT_FLASH_CYCLES
) (
    input  logic                  clock_100mhz,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] word_in,
    input  logic                  lock,
    output logic [NUM_REQ-1:0]    grant,
    output logic [31:0]           dword,
    output logic                  flash_upper_half,
    output logic                  flash_lower_half,
    output logic [2:0]            owner_idx,
    output logic                  owner_valid
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    arb_state_t          state_q, state_d;
    logic [2:0]          owner_q, owner_d;
    logic [2:0]          rr_q, rr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [31:0]         dword_q, dword_d;
    logic                flash_q, flash_d;
    logic                valid_q, valid_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;

    logic [NUM_REQ-1:0]  pick_req;
    logic [2:0]          pick_start;
    logic [2:0]          pick_idx;
    logic                pick_found;
    logic [31:0]         owner_word;
    logic [31:0]         win_word;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                owner_req;
    logic                take;

    // From IDLE the search starts at the rr pointer; on hold expiry the
    // current owner is masked out and the search starts just after it.
    assign pick_req   = (state_q == IDLE) ? req : (req & ~grant_q);
    assign pick_start = (state_q == IDLE) ? rr_q : wrap_inc(owner_q, NUM_REQ);

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (pick_req),
        .start  (pick_start),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        owner_word = '0;
        win_word   = '0;
        win_onehot = '0;
        owner_req  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                owner_word = word_in[i*32 +: 32];
                owner_req  = req[i];
            end
            if (pick_idx == 3'(i)) begin
                win_word      = word_in[i*32 +: 32];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        dword_d = dword_q;
        flash_d = flash_q;
        valid_d = valid_q;
        hold_d  = (hold_q == '0) ? '0 : hold_q - 1'b1;
        fcnt_d  = (fcnt_q == '0) ? '0 : fcnt_q - 1'b1;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                // lock only blocks rotation, so an idle display is still granted
                take = pick_found;
            end
            ANNOUNCE: begin
                dword_d = owner_word;
                if (fcnt_q == '0) begin
                    state_d = OWNED;
                    flash_d = 1'b0;
                end
            end
            OWNED: begin
                // a dropped owner request freezes the last shown word
                if (owner_req) begin
                    dword_d = owner_word;
                end
                if (hold_q == '0 && !lock) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        owner_d = '0;
                        grant_d = '0;
                        dword_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d = ANNOUNCE;
            owner_d = pick_idx;
            rr_d    = wrap_inc(pick_idx, NUM_REQ);
            grant_d = win_onehot;
            dword_d = win_word;
            flash_d = 1'b1;
            valid_d = 1'b1;
            hold_d  = HW'(HOLD_CYCLES - 1);
            fcnt_d  = FW'(FLASH_CYCLES - 1);
        end
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            dword_q <= '0;
            flash_q <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            dword_q <= dword_d;
            flash_q <= flash_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign grant            = grant_q;
    assign dword            = dword_q;
    assign flash_upper_half = flash_q;
    assign flash_lower_half = flash_q;
    assign owner_idx        = owner_q;
    assign owner_valid      = valid_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter
module tb_display_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 4;
    localparam int FLASH = 2;
    localparam int NV    = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            lock;
    logic [31:0]     words [N];
    logic [N*32-1:0] word_in;
    logic [N-1:0]    grant;
    logic [31:0]     dword;
    logic            fu;
    logic            fl;
    logic [2:0]      owner_idx;
    logic            owner_valid;

    int total = 0;
    int bad   = 0;

    // reference model: owner (-1 = idle), edges since the grant, rr pointer, shown word
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_rr    = 0;
    logic [31:0] m_shown = '0;

    always #5 clk = ~clk;

    assign word_in = {words[3], words[2], words[1], words[0]};

    display_arbiter #(
        .NUM_REQ      (N),
        .HOLD_CYCLES  (HOLD),
        .FLASH_CYCLES (FLASH)
    ) dut (
        .clock_100mhz     (clk),
        .reset            (rst),
        .req              (req),
        .word_in          (word_in),
        .lock             (lock),
        .grant            (grant),
        .dword            (dword),
        .flash_upper_half (fu),
        .flash_lower_half (fl),
        .owner_idx        (owner_idx),
        .owner_valid      (owner_valid)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  grant;
        logic        flash;
        logic        valid;
        logic [2:0]  idx;
        logic [31:0] dword;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic f, input logic v, input logic [2:0] i,
                                input logic [31:0] d);
        vec_t t;
        t.rst = r; t.req = q; t.grant = g; t.flash = f; t.valid = v; t.idx = i; t.dword = d;
        return t;
    endfunction

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic claim(input int c);
        m_owner = c;
        m_age   = 0;
        m_rr    = (c + 1) % N;
        m_shown = words[c[1:0]];
    endtask

    task automatic model_edge();
        if (rst) begin
            m_owner = -1;
            m_age   = 0;
            m_rr    = 0;
            m_shown = '0;
        end else if (m_owner < 0) begin
            int pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && bit_of(req, (m_rr + k) % N)) pick = (m_rr + k) % N;
            end
            if (pick >= 0) claim(pick);
        end else begin
            int nxt = -1;
            if (m_age < FLASH || bit_of(req, m_owner)) m_shown = words[m_owner[1:0]];
            if (m_age >= HOLD - 1 && m_age >= FLASH && !lock) begin
                for (int k = 1; k < N; k++) begin
                    if (nxt < 0 && bit_of(req, (m_owner + k) % N)) nxt = (m_owner + k) % N;
                end
                if (nxt >= 0) begin
                    claim(nxt);
                end else if (!bit_of(req, m_owner)) begin
                    m_owner = -1;
                    m_age   = 0;
                    m_shown = '0;
                end
            end else if (m_age < 1000) begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] g, input logic f,
                              input logic v, input logic [2:0] i, input logic [31:0] d);
        cmp({tag, ".grant"}, 32'(grant), 32'(g));
        cmp({tag, ".flash_up"}, 32'(fu), 32'(f));
        cmp({tag, ".flash_lo"}, 32'(fl), 32'(f));
        cmp({tag, ".valid"}, 32'(owner_valid), 32'(v));
        cmp({tag, ".idx"}, 32'(owner_idx), 32'(i));
        cmp({tag, ".dword"}, dword, d);
    endtask

    task automatic expect_model(input string tag);
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        expect_all(tag, g, (m_owner >= 0) && (m_age < FLASH), m_owner >= 0,
                   (m_owner < 0) ? 3'd0 : m_owner[2:0], m_shown);
    endtask

    initial begin
        logic [31:0] w0, w1, w3;
        rst  = 1'b1;
        req  = '0;
        lock = 1'b0;
        for (int i = 0; i < N; i++) words[i] = 32'h1111_0000 + 32'(i);
        w0 = words[0];
        w1 = words[1];
        w3 = words[3];

        // reset with all requesting, release, then rotation over 4'b1010
        tbl[0]  = mk(1, 4'hf, 4'b0000, 0, 0, 3'd0, 32'h0);
        tbl[1]  = mk(1, 4'hf, 4'b0000, 0, 0, 3'd0, 32'h0);
        tbl[2]  = mk(1, 4'hf, 4'b0000, 0, 0, 3'd0, 32'h0);
        tbl[3]  = mk(0, 4'hf, 4'b0001, 1, 1, 3'd0, w0);
        tbl[4]  = mk(0, 4'hf, 4'b0001, 1, 1, 3'd0, w0);
        tbl[5]  = mk(0, 4'hf, 4'b0001, 0, 1, 3'd0, w0);
        tbl[6]  = mk(0, 4'hf, 4'b0001, 0, 1, 3'd0, w0);
        tbl[7]  = mk(0, 4'hf, 4'b0010, 1, 1, 3'd1, w1);
        tbl[8]  = mk(1, 4'ha, 4'b0000, 0, 0, 3'd0, 32'h0);
        tbl[9]  = mk(0, 4'ha, 4'b0010, 1, 1, 3'd1, w1);
        tbl[10] = mk(0, 4'ha, 4'b0010, 1, 1, 3'd1, w1);
        tbl[11] = mk(0, 4'ha, 4'b0010, 0, 1, 3'd1, w1);
        tbl[12] = mk(0, 4'ha, 4'b0010, 0, 1, 3'd1, w1);
        tbl[13] = mk(0, 4'ha, 4'b1000, 1, 1, 3'd3, w3);
        tbl[14] = mk(0, 4'ha, 4'b1000, 1, 1, 3'd3, w3);
        tbl[15] = mk(0, 4'ha, 4'b1000, 0, 1, 3'd3, w3);
        tbl[16] = mk(0, 4'ha, 4'b1000, 0, 1, 3'd3, w3);
        tbl[17] = mk(0, 4'ha, 4'b0010, 1, 1, 3'd1, w1);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            tick();
            expect_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].flash, tbl[i].valid,
                       tbl[i].idx, tbl[i].dword);
        end

        // single-cycle request: ownership kept through the hold, word frozen, then idle
        rst = 1'b1; req = '0; tick();
        rst = 1'b0;
        words[2] = 32'hCAFE_0002;
        req = 4'b0100; tick();
        expect_all("rel_e0", 4'b0100, 1, 1, 3'd2, 32'hCAFE_0002);
        req = 4'b0000; tick();
        expect_all("rel_e1", 4'b0100, 1, 1, 3'd2, 32'hCAFE_0002);
        tick();
        expect_all("rel_e2", 4'b0100, 0, 1, 3'd2, 32'hCAFE_0002);
        words[2] = 32'hDEAD_BEEF; tick();
        expect_all("rel_e3", 4'b0100, 0, 1, 3'd2, 32'hCAFE_0002);
        tick();
        expect_all("rel_idle", 4'b0000, 0, 0, 3'd0, 32'h0);
        words[2] = 32'h1111_0002;

        // lock holds owner 0 against all requests, release rotates to 1
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0001; tick();
        cmp("lock_first", 32'(grant), 32'h1);
        lock = 1'b1; req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            cmp($sformatf("lock_hold%0d", i), 32'(grant), 32'h1);
        end
        lock = 1'b0; tick();
        cmp("lock_release_grant", 32'(grant), 32'h2);
        cmp("lock_release_flash", 32'(fu), 32'h1);

        // wrap from owner 3 to owner 0; the rr pointer then starts at 1
        rst = 1'b1; tick();
        rst = 1'b0; lock = 1'b0; req = 4'b1000; tick();
        cmp("wrap_first", 32'(grant), 32'h8);
        for (int i = 0; i < 3; i++) tick();
        cmp("wrap_last_of_3", 32'(grant), 32'h8);
        req = 4'b1001; tick();
        cmp("wrap_grant", 32'(grant), 32'h1);
        cmp("wrap_idx", 32'(owner_idx), 32'h0);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        cmp("wrap_idle_valid", 32'(owner_valid), 32'h0);
        cmp("wrap_idle_dword", dword, 32'h0);
        req = 4'b1111; tick();
        cmp("wrap_rr_grant", 32'(grant), 32'h2);

        // reset while announcing
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0001; tick();
        cmp("rstmid_flash_before", 32'(fu), 32'h1);
        rst = 1'b1; tick();
        expect_all("rstmid", 4'b0000, 0, 0, 3'd0, 32'h0);
        rst = 1'b0; req = 4'b0010; tick();
        expect_all("rstmid_after", 4'b0010, 1, 1, 3'd1, w1);

        // randomized traffic against the reference model
        rst = 1'b1; req = '0; lock = 1'b0; tick();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic [1:0] wi;
            req = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 19) == 0) lock = ~lock;
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) begin
                wi = 2'($urandom_range(0, 3));
                words[wi] = $urandom;
            end
            tick();
            expect_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
